// File: rtl/probe_mux_scheduler.sv
// probe_mux_scheduler
// Controller for the 8-bit JA PMOD oscilloscope probe multiplexer. It picks
// which probe group (SPI = 1, GPIO = 2, SCB = 3) is routed to the scope
// header. In manual mode the host selects the group. In auto mode the block
// scans round-robin over the requesting groups with a fixed dwell time. Every
// switch is preceded by a blanking guard. A one-cycle trigger marks the first
// cycle of valid data.
//
// Ports
//   clk           system clock
//   rst           synchronous, active-high reset
//   enable        scheduler enable; low forces IDLE
//   auto_mode     1 = round-robin auto-scan, 0 = manual
//   manual_sel    manual group code, 0 = none
//   dwell_cycles  auto-mode dwell length in cycles (0 behaves as 1)
//   grp_req       visibility requests: bit0 SPI, bit1 GPIO, bit2 SCB
//   hold          freezes the dwell counter while the scope is armed
//   probe_sel     operation-mode code driven to the probe mux
//   probe_blank   1 = mux output must be forced to 0
//   trig_pulse    one-cycle marker on the first valid-data cycle
//   busy          high while in GUARD or DWELL
//   sw_count      completed switches, wraps 255 -> 0
module probe_mux_scheduler #(
  parameter int DWELL_W      = 16,
  parameter int GUARD_CYCLES = 4    // legal range 1..15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               auto_mode,
  input  logic [1:0]         manual_sel,
  input  logic [DWELL_W-1:0] dwell_cycles,
  input  logic [2:0]         grp_req,
  input  logic               hold,
  output logic [1:0]         probe_sel,
  output logic               probe_blank,
  output logic               trig_pulse,
  output logic               busy,
  output logic [7:0]         sw_count
);

  typedef enum logic [1:0] {IDLE, GUARD, DWELL} state_t;

  localparam logic [3:0]         GUARD_LAST = 4'(GUARD_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);

  state_t             state_q, state_d;
  logic [1:0]         target_q, target_d;
  logic [1:0]         last_grant_q, last_grant_d;
  logic [3:0]         guard_cnt_q, guard_cnt_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic               auto_mode_q, auto_mode_d;
  logic [1:0]         probe_sel_q, probe_sel_d;
  logic               probe_blank_q, probe_blank_d;
  logic               trig_q, trig_d;
  logic               busy_q, busy_d;
  logic [7:0]         sw_count_q, sw_count_d;

  logic               mode_flip;
  logic [DWELL_W-1:0] dwell_last;
  logic [1:0]         idle_pick;
  logic [1:0]         scan_next;

  // First requesting group strictly after 'from' in the cyclic order
  // 1 -> 2 -> 3 -> 1. 'from' itself is checked last, so it is returned only
  // when it is the sole requester. Returns 0 when nobody requests.
  function automatic logic [1:0] next_grp(input logic [1:0] from,
                                          input logic [2:0] req);
    logic [1:0] g;
    logic [1:0] res;
    g   = from;
    res = 2'd0;
    for (int i = 0; i < 3; i++) begin
      g = (g == 2'd3) ? 2'd1 : g + 2'd1;
      if (res == 2'd0 && req[g - 2'd1]) res = g;
    end
    return res;
  endfunction

  assign mode_flip  = auto_mode ^ auto_mode_q;
  assign dwell_last = (dwell_cycles == '0) ? '0 : dwell_cycles - DWELL_ONE;
  assign idle_pick  = auto_mode ? next_grp(last_grant_q, grp_req) : manual_sel;
  assign scan_next  = next_grp(probe_sel_q, grp_req);

  // State and datapath registers
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      target_q      <= 2'd0;
      last_grant_q  <= 2'd3;
      guard_cnt_q   <= '0;
      dwell_cnt_q   <= '0;
      auto_mode_q   <= 1'b0;
      probe_sel_q   <= 2'd0;
      probe_blank_q <= 1'b1;
      trig_q        <= 1'b0;
      busy_q        <= 1'b0;
      sw_count_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      last_grant_q  <= last_grant_d;
      guard_cnt_q   <= guard_cnt_d;
      dwell_cnt_q   <= dwell_cnt_d;
      auto_mode_q   <= auto_mode_d;
      probe_sel_q   <= probe_sel_d;
      probe_blank_q <= probe_blank_d;
      trig_q        <= trig_d;
      busy_q        <= busy_d;
      sw_count_q    <= sw_count_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    target_d    = target_q;
    guard_cnt_d = guard_cnt_q;
    dwell_cnt_d = dwell_cnt_q;
    auto_mode_d = auto_mode;

    if (!enable) begin
      state_d = IDLE;
    end else if (state_q != IDLE && mode_flip) begin
      // A mode change wins over every other transition, dwell expiry included.
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (idle_pick != 2'd0) begin
            state_d     = GUARD;
            target_d    = idle_pick;
            guard_cnt_d = '0;
          end
        end
        GUARD: begin
          if (guard_cnt_q == GUARD_LAST) begin
            state_d     = DWELL;
            dwell_cnt_d = '0;
          end else begin
            guard_cnt_d = guard_cnt_q + 4'd1;
          end
        end
        DWELL: begin
          if (!auto_mode) begin
            if (manual_sel == 2'd0) begin
              state_d = IDLE;
            end else if (manual_sel != probe_sel_q) begin
              state_d     = GUARD;
              target_d    = manual_sel;
              guard_cnt_d = '0;
            end
          end else if (!hold) begin
            if (dwell_cnt_q == dwell_last) begin
              if (scan_next == 2'd0) begin
                state_d = IDLE;
              end else if (scan_next == probe_sel_q) begin
                // Sole requester: restart the dwell without reblanking.
                dwell_cnt_d = '0;
              end else begin
                state_d     = GUARD;
                target_d    = scan_next;
                guard_cnt_d = '0;
              end
            end else begin
              dwell_cnt_d = dwell_cnt_q + DWELL_ONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Registered outputs are derived from the state being entered.
  always_comb begin
    probe_sel_d   = (state_d == IDLE) ? 2'd0 : target_d;
    probe_blank_d = (state_d != DWELL);
    trig_d        = (state_q == GUARD) && (state_d == DWELL);
    busy_d        = (state_d != IDLE);
    sw_count_d    = trig_d ? sw_count_q + 8'd1 : sw_count_q;
    last_grant_d  = trig_d ? target_q : last_grant_q;
  end

  assign probe_sel   = probe_sel_q;
  assign probe_blank = probe_blank_q;
  assign trig_pulse  = trig_q;
  assign busy        = busy_q;
  assign sw_count    = sw_count_q;

endmodule
